rs_corr_buffer: RTL and testbench

//  Downstream correction stage for the byte-serial RS(255,k) decoder. Stores received codeword

---
 rtl/rs_corr_buffer.sv | 151 +++++++++++++++
 tb/tb_rs_corr_buffer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/rs_corr_buffer.sv
// Correction stage for a byte-serial RS(255,k) decoder: FIFO of received bytes, XOR with decoder
// error magnitudes, codeword framing. Define RS_CORR_STATS_EN to enable the corrected-symbol counters.
module rs_corr_buffer #(
  parameter int DEPTH = 512,
  parameter int DW    = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DW-1:0]              in_data,
  input  logic                       in_valid,
  input  logic [DW-1:0]              dec_error,
  input  logic                       dec_valid,
  input  logic [7:0]                 cw_len,
  output logic [DW-1:0]              out_data,
  output logic                       out_valid,
  output logic                       out_last,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       overflow,
  output logic                       underflow,
  output logic [7:0]                 corr_cnt,
  output logic                       corr_cnt_valid,
  output logic [31:0]                corr_total
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic [7:0]    pos_q, pos_d;
  logic [DW-1:0] out_data_q;
  logic          out_valid_q, out_last_q, overflow_q, underflow_q;

  logic full_s, empty_s, pop_s, push_s, drop_s, last_pos_s;
  logic [DW-1:0] rd_byte_s;

  assign full_s     = (level_q == LVL_FULL);
  assign empty_s    = (level_q == {(AW+1){1'b0}});
  assign pop_s      = dec_valid & ~empty_s;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside a pop.
  assign push_s     = in_valid & (~full_s | pop_s);
  assign drop_s     = in_valid & full_s & ~pop_s;
  assign last_pos_s = pop_s & (pos_q == (cw_len - 8'd1));
  assign rd_byte_s  = mem_q[rd_ptr_q];

  // Next-state for pointers, occupancy and codeword position.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    pos_d    = pos_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
    if (last_pos_s) begin
      pos_d = 8'd0;
    end else if (pop_s) begin
      pos_d = pos_q + 8'd1;
    end else begin
      pos_d = pos_q;
    end
  end

  // Storage array; contents are meaningless after reset because the pointers are cleared.
  always_ff @(posedge clk) begin
    if (push_s) mem_q[wr_ptr_q] <= in_data;
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= {AW{1'b0}};
      rd_ptr_q    <= {AW{1'b0}};
      level_q     <= {(AW+1){1'b0}};
      pos_q       <= 8'd0;
      out_data_q  <= {DW{1'b0}};
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      pos_q       <= pos_d;
      out_valid_q <= dec_valid;
      out_last_q  <= last_pos_s;
      if (dec_valid) out_data_q <= pop_s ? (rd_byte_s ^ dec_error) : dec_error;
      if (drop_s) overflow_q <= 1'b1;
      if (dec_valid & empty_s) underflow_q <= 1'b1;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign fifo_level = level_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

`ifdef RS_CORR_STATS_EN
  logic [7:0]  acc_q, corr_cnt_q;
  logic        corr_cnt_valid_q;
  logic [31:0] corr_total_q;
  logic        nz_s;

  assign nz_s = dec_valid & (dec_error != {DW{1'b0}});

  // Per-codeword and running counts of nonzero error symbols.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q            <= 8'd0;
      corr_cnt_q       <= 8'd0;
      corr_cnt_valid_q <= 1'b0;
      corr_total_q     <= 32'd0;
    end else begin
      corr_cnt_valid_q <= last_pos_s;
      if (last_pos_s) begin
        corr_cnt_q <= acc_q + {7'd0, nz_s};
        acc_q      <= 8'd0;
      end else if (nz_s) begin
        acc_q <= acc_q + 8'd1;
      end
      if (nz_s && (corr_total_q != 32'hFFFF_FFFF)) corr_total_q <= corr_total_q + 32'd1;
    end
  end

  assign corr_cnt       = corr_cnt_q;
  assign corr_cnt_valid = corr_cnt_valid_q;
  assign corr_total     = corr_total_q;
`else
  assign corr_cnt       = 8'd0;
  assign corr_cnt_valid = 1'b0;
  assign corr_total     = 32'd0;
`endif

endmodule

// File: tb/tb_rs_corr_buffer.sv
// Self-checking bench for rs_corr_buffer: constant vector table, directed word sequences and
// random traffic compared against a queue-based reference model.
module tb_rs_corr_buffer;
  localparam int DEPTH = 512;
  localparam int DW    = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] in_data = 8'd0, dec_error = 8'd0;
  logic          in_valid = 1'b0, dec_valid = 1'b0;
  logic [7:0]    cw_len = 8'd255;
  logic [DW-1:0] out_data;
  logic          out_valid, out_last, overflow, underflow, corr_cnt_valid;
  logic [9:0]    fifo_level;
  logic [7:0]    corr_cnt;
  logic [31:0]   corr_total;

  rs_corr_buffer #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .dec_error(dec_error), .dec_valid(dec_valid), .cw_len(cw_len),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .fifo_level(fifo_level), .overflow(overflow), .underflow(underflow),
    .corr_cnt(corr_cnt), .corr_cnt_valid(corr_cnt_valid), .corr_total(corr_total)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: FIFO contents as a queue plus framing and statistics bookkeeping.
  logic [7:0]  q[$];
  int          m_pos, m_acc, m_cnt;
  logic [31:0] m_tot;
  bit          m_ov, m_uf, e_valid, e_last, e_cv;
  logic [7:0]  e_data;
  int          max_level;

  typedef struct {
    logic       iv; logic [7:0] id; logic dv; logic [7:0] de;
    logic       ev; logic [7:0] ed; logic el; logic [9:0] elvl; logic euf;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_pos = 0; m_acc = 0; m_cnt = 0; m_tot = 32'd0;
    m_ov = 1'b0; m_uf = 1'b0; e_valid = 1'b0; e_last = 1'b0; e_cv = 1'b0; e_data = 8'd0;
  endtask

  task automatic check_model();
    chk("out_valid", out_valid, e_valid);
    chk("out_last", out_last, e_last);
    if (e_valid) chk("out_data", out_data, e_data);
    chk("fifo_level", fifo_level, q.size());
    chk("overflow", overflow, m_ov);
    chk("underflow", underflow, m_uf);
`ifdef RS_CORR_STATS_EN
    chk("corr_cnt_valid", corr_cnt_valid, e_cv);
    chk("corr_cnt", corr_cnt, m_cnt);
    chk("corr_total", corr_total, m_tot);
`else
    chk("corr_cnt_valid", corr_cnt_valid, 0);
    chk("corr_cnt", corr_cnt, 0);
    chk("corr_total", corr_total, 0);
`endif
  endtask

  task automatic step(input logic iv, input logic [7:0] id, input logic dv, input logic [7:0] de);
    int  sz;
    bit  pop;
    in_valid = iv; in_data = id; dec_valid = dv; dec_error = de;
    sz  = q.size();
    pop = dv && (sz > 0);
    e_cv = 1'b0;
    e_last = 1'b0;
    e_valid = dv;
    if (dv && de != 8'd0) begin
      m_acc++;
      if (m_tot != 32'hFFFF_FFFF) m_tot = m_tot + 32'd1;
    end
    if (pop) begin
      e_data = q.pop_front() ^ de;
      if (m_pos == int'(cw_len) - 1) begin
        e_last = 1'b1; e_cv = 1'b1; m_pos = 0; m_cnt = m_acc; m_acc = 0;
      end else begin
        m_pos++;
      end
    end else if (dv) begin
      e_data = de;
      m_uf = 1'b1;
    end
    if (iv) begin
      if (sz < DEPTH || pop) q.push_back(id);
      else m_ov = 1'b1;
    end
    @(posedge clk); #1;
    check_model();
    if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
  endtask

  task automatic do_reset();
    in_valid = 1'b0; dec_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_corr_cnt", corr_cnt, 0);
    chk("rst_corr_cnt_valid", corr_cnt_valid, 0);
    chk("rst_corr_total", corr_total, 0);
    model_clear();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [7:0] rnd_err();
    return ($urandom_range(0, 9) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
  endfunction

  logic [7:0] word[256];
  int         last_idx;

  initial begin
    tbl[0] = '{1'b0, 8'h00, 1'b1, 8'h33, 1'b1, 8'h33, 1'b0, 10'd0, 1'b1};
    tbl[1] = '{1'b1, 8'hA1, 1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 10'd1, 1'b1};
    tbl[2] = '{1'b1, 8'hB2, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 10'd2, 1'b1};
    tbl[3] = '{1'b1, 8'hC3, 1'b1, 8'h0F, 1'b1, 8'hAE, 1'b0, 10'd2, 1'b1};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 8'hB2, 1'b0, 10'd1, 1'b1};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 8'hFF, 1'b1, 8'h3C, 1'b1, 10'd0, 1'b1};
    tbl[6] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 10'd0, 1'b1};

    // Vector table: underflow, no-bypass push, and a 3-byte codeword.
    do_reset();
    cw_len = 8'd3;
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].iv, tbl[i].id, tbl[i].dv, tbl[i].de);
      chk("tbl_valid", out_valid, tbl[i].ev);
      if (tbl[i].ev) chk("tbl_data", out_data, tbl[i].ed);
      chk("tbl_last", out_last, tbl[i].el);
      chk("tbl_level", fifo_level, tbl[i].elvl);
      chk("tbl_underflow", underflow, tbl[i].euf);
    end

    // Clean 255-byte word.
    do_reset();
    cw_len = 8'd255;
    for (int i = 0; i < 255; i++) step(1'b1, 8'(i), 1'b0, 8'd0);
    chk("t1_level", fifo_level, 255);
    for (int i = 0; i < 255; i++) begin
      step(1'b0, 8'd0, 1'b1, 8'd0);
      chk("t1_data", out_data, i);
      chk("t1_last", out_last, (i == 254) ? 1 : 0);
    end
    chk("t1_corr_cnt", corr_cnt, 0);

    // Two corrections in one word.
    for (int i = 0; i < 255; i++) begin
      word[i] = 8'($urandom);
      step(1'b1, word[i], 1'b0, 8'd0);
    end
    for (int i = 0; i < 255; i++) begin
      step(1'b0, 8'd0, 1'b1, (i == 3) ? 8'h5A : ((i == 200) ? 8'h01 : 8'h00));
      if (i == 3)   chk("t2_pos3", out_data, word[3] ^ 8'h5A);
      if (i == 200) chk("t2_pos200", out_data, word[200] ^ 8'h01);
    end
`ifdef RS_CORR_STATS_EN
    chk("t2_corr_cnt", corr_cnt, 2);
    chk("t2_corr_total", corr_total, 2);
`else
    chk("t2_corr_cnt", corr_cnt, 0);
    chk("t2_corr_total", corr_total, 0);
`endif

    // Overlap: word B pushed while word A drains.
    max_level = 0;
    for (int i = 0; i < 255; i++) step(1'b1, 8'($urandom), 1'b0, 8'd0);
    for (int i = 0; i < 255; i++) step(1'b1, 8'($urandom), 1'b1, rnd_err());
    for (int i = 0; i < 255; i++) step(1'b0, 8'd0, 1'b1, rnd_err());
    chk("t3_peak_ok", (max_level <= 510) ? 1 : 0, 1);
    chk("t3_no_overflow", overflow, 0);

    // Full FIFO: the 513th byte is dropped, a push with a pop is still accepted.
    do_reset();
    cw_len = 8'd255;
    for (int i = 0; i < 513; i++) step(1'b1, 8'(i + 1), 1'b0, 8'd0);
    chk("t4_overflow", overflow, 1);
    chk("t4_level", fifo_level, 512);
    step(1'b1, 8'hEE, 1'b1, 8'd0);
    chk("t4_first_out", out_data, 8'h01);
    chk("t4_level_pp", fifo_level, 512);
    for (int i = 0; i < 512; i++) begin
      step(1'b0, 8'd0, 1'b1, 8'd0);
      if (i == 510) chk("t4_byte512", out_data, 8'h00);
    end
    chk("t4_tail_is_514th", out_data, 8'hEE);

    // Reset mid-codeword, then a fresh 16-byte word.
    do_reset();
    cw_len = 8'd255;
    for (int i = 0; i < 150; i++) step(1'b1, 8'($urandom), 1'b0, 8'd0);
    for (int i = 0; i < 100; i++) step(1'b0, 8'd0, 1'b1, rnd_err());
    do_reset();
    cw_len = 8'd16;
    for (int i = 0; i < 16; i++) step(1'b1, 8'($urandom), 1'b0, 8'd0);
    last_idx = -1;
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 8'd0, 1'b1, rnd_err());
      if (out_last) last_idx = i;
    end
    chk("t6_last_idx", last_idx, 15);

    // Random mixed traffic with short codewords, including cw_len=1.
    for (int r = 0; r < 6; r++) begin
      do_reset();
      cw_len = (r == 0) ? 8'd1 : 8'($urandom_range(2, 8));
      for (int c = 0; c < 300; c++)
        step(($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0, 8'($urandom),
             ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0, rnd_err());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
